// File: rtl/wave_sel_pio_in.sv
// wave_sel_pio_in
// Avalon-MM input PIO for board switches/keys. The asynchronous inputs are
// brought into the clock domain through a two-flop synchronizer, optionally
// debounced, and exposed as a level (DATA) plus per-bit sticky edge-capture
// bits (CAPTURE). Captured edges that are enabled in MASK raise a level irq.
//
// Register map (unused readdata bits read 0):
//   0 DATA    RO   stable input level
//   1 EDGE    RW   [1:0]: 00 rising, 01 falling, 1x any edge
//   2 MASK    RW   irq enable per bit
//   3 CAPTURE RW1C sticky edge flags, write 1 to clear
//
// Ports:
//   clk        system clock (single domain)
//   reset      asynchronous, active-high reset
//   address    register select
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   read data, combinational from address (zero wait states)
//   in_port    asynchronous external inputs
//   irq        active-high level interrupt = |(CAPTURE & MASK)
//
// Optional feature: define WAVE_SEL_PIO_IN_DEBOUNCE_EN to add a per-bit
// debounce filter requiring DEBOUNCE_CYCLES stable cycles before the level
// is accepted. Without it, the synchronizer output is used directly.

module wave_sel_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [1:0]       edge_sel_q, edge_sel_d;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;

    // Upper writedata bits are architecturally ignored; DEBOUNCE_CYCLES has
    // no role in the plain build.
    logic unused_ok;
    assign unused_ok = ^writedata ^ (DEBOUNCE_CYCLES < 1);

    assign wr = chipselect & ~write_n;

`ifdef WAVE_SEL_PIO_IN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Per-bit debounce: count cycles where the synchronized input disagrees
    // with the accepted level. The counter's next value reaching
    // DEBOUNCE_CYCLES is when the new level is accepted, so comparing the
    // current value against DEBOUNCE_CYCLES-1 lands the update exactly
    // DEBOUNCE_CYCLES cycles after s2 changed. Any agreeing cycle restarts it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = s2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
`else
    assign stable = s2_q;
`endif

    // Edge selection: EDGE[1] set means any transition, otherwise EDGE[0]
    // picks falling (1) or rising (0).
    always_comb begin
        edge_det = '0;
        if (edge_sel_q[1]) begin
            edge_det = stable ^ prev_q;
        end else if (edge_sel_q[0]) begin
            edge_det = ~stable & prev_q;
        end else begin
            edge_det = stable & ~prev_q;
        end
    end

    // Next-state for synchronizer, edge history and the software registers.
    // The capture OR is applied after the clear so that an edge arriving in
    // the same cycle as a W1C of that bit keeps the bit set.
    always_comb begin
        s1_d       = in_port;
        s2_d       = s1_q;
        prev_d     = stable;
        mask_d     = mask_q;
        edge_sel_d = edge_sel_q;
        clr        = '0;

        if (wr && address == 2'd1) begin
            edge_sel_d = writedata[1:0];
        end
        if (wr && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end

        cap_d = (cap_q & ~clr) | edge_det;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            cap_q      <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            prev_q     <= prev_d;
            cap_q      <= cap_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
        end
    end

    // Zero-latency read mux.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable;
            2'd1:    readdata[1:0]       = edge_sel_q;
            2'd2:    readdata[WIDTH-1:0] = mask_q;
            default: readdata[WIDTH-1:0] = cap_q;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_wave_sel_pio_in.sv
// tb_wave_sel_pio_in
// Directed bench for wave_sel_pio_in (WIDTH=4). Each read issued by the
// stimulus pushes its hand-computed expected readdata/irq into a scoreboard;
// a separate monitor pops and compares whenever a read strobe is presented.
// Latencies shift by DEBOUNCE_CYCLES when WAVE_SEL_PIO_IN_DEBOUNCE_EN is set.

module tb_wave_sel_pio_in;

    localparam int W = 4;
`ifdef WAVE_SEL_PIO_IN_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port;
    logic          irq;

    logic          rd_req = 1'b0;
    int            checks = 0;
    int            errors = 0;

    logic [31:0]   exp_data_q[$];
    logic          exp_irq_q[$];
    string         name_q[$];

    logic [31:0]   e_data;
    logic          e_irq;
    string         e_name;

    wave_sel_pio_in #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    // 20 ns clock; reads are done mid-cycle, well away from the rising edge.
    always #10 clk = ~clk;

    // Monitor: on every read strobe pop the expected entry and compare.
    always @(posedge rd_req) begin
        if (exp_data_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_read: got readdata=0x%08h with no expected entry", readdata);
        end else begin
            e_data = exp_data_q.pop_front();
            e_irq  = exp_irq_q.pop_front();
            e_name = name_q.pop_front();
            checks++;
            if (readdata !== e_data) begin
                errors++;
                $display("[TB] FAIL %s readdata: got 0x%08h expected 0x%08h", e_name, readdata, e_data);
            end
            checks++;
            if (irq !== e_irq) begin
                errors++;
                $display("[TB] FAIL %s irq: got %b expected %b", e_name, irq, e_irq);
            end
        end
    end

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] v);
        in_port = v;
    endtask

    // Issue a read and queue its expected result; takes 2 ns, no clock edge.
    task automatic checkOutput(input string name, input logic [1:0] a,
                               input logic [31:0] d, input logic i);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        name_q.push_back(name);
        exp_data_q.push_back(d);
        exp_irq_q.push_back(i);
        #1 rd_req = 1'b1;
        #1 rd_req = 1'b0;
        chipselect = 1'b0;
    endtask

    // Single write; takes effect at the next rising edge, returns 1 ns after.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'b0101;

        // Reset with inputs held high on bits 0 and 2.
        tick(3);
        checkOutput("rst_data", 2'd0, 32'h0, 1'b0);
        checkOutput("rst_edge", 2'd1, 32'h0, 1'b0);
        checkOutput("rst_mask", 2'd2, 32'h0, 1'b0);
        checkOutput("rst_cap",  2'd3, 32'h0, 1'b0);
        reset = 1'b0;
        tick(1 + DB);
        checkOutput("rel_data_early", 2'd0, 32'h0, 1'b0);
        tick(1);
        checkOutput("rel_data", 2'd0, 32'h5, 1'b0);
        checkOutput("rel_cap_early", 2'd3, 32'h0, 1'b0);
        tick(1);
        checkOutput("rel_cap", 2'd3, 32'h5, 1'b0);

        // Rising capture with MASK enabled, then W1C.
        bus_write(2'd3, 32'hF);
        checkOutput("clr_all", 2'd3, 32'h0, 1'b0);
        applyStimulus(4'b0000);
        tick(3 + DB);
        checkOutput("fall_in_rise_mode", 2'd3, 32'h0, 1'b0);
        bus_write(2'd2, 32'hF);
        checkOutput("mask_rd", 2'd2, 32'hF, 1'b0);
        applyStimulus(4'b1000);
        tick(2 + DB);
        checkOutput("bit3_data", 2'd0, 32'h8, 1'b0);
        checkOutput("bit3_cap_early", 2'd3, 32'h0, 1'b0);
        tick(1);
        checkOutput("bit3_cap", 2'd3, 32'h8, 1'b1);
        bus_write(2'd3, 32'h8);
        checkOutput("bit3_clr", 2'd3, 32'h0, 1'b0);

        // Falling-edge mode.
        bus_write(2'd1, 32'h1);
        checkOutput("edge_fall_rd", 2'd1, 32'h1, 1'b0);
        applyStimulus(4'hF);
        tick(3 + DB);
        checkOutput("rise_in_fall_mode", 2'd3, 32'h0, 1'b0);
        applyStimulus(4'hE);
        tick(3 + DB);
        checkOutput("fall_cap", 2'd3, 32'h1, 1'b1);
        bus_write(2'd3, 32'hF);

        // Any-edge mode, bit 2 toggles 1->0->1.
        bus_write(2'd1, 32'h2);
        checkOutput("edge_any_rd", 2'd1, 32'h2, 1'b0);
        applyStimulus(4'hA);
        tick(3 + DB);
        checkOutput("any_fall_cap", 2'd3, 32'h4, 1'b1);
        bus_write(2'd3, 32'h4);
        checkOutput("any_clr", 2'd3, 32'h0, 1'b0);
        applyStimulus(4'hE);
        tick(3 + DB);
        checkOutput("any_rise_cap", 2'd3, 32'h4, 1'b1);
        bus_write(2'd3, 32'hF);

        // Edge and clear of bit 0 at the same edge: the edge wins.
        bus_write(2'd1, 32'h0);
        applyStimulus(4'hF);
        tick(2 + DB);
        bus_write(2'd3, 32'h1);
        checkOutput("edge_beats_clr", 2'd3, 32'h1, 1'b1);
        bus_write(2'd3, 32'h1);
        checkOutput("clr_after_race", 2'd3, 32'h0, 1'b0);

        // Mid-operation asynchronous reset.
        applyStimulus(4'hC);
        tick(3 + DB);
        bus_write(2'd3, 32'hF);
        applyStimulus(4'hF);
        tick(3 + DB);
        bus_write(2'd2, 32'h3);
        checkOutput("pre_rst_cap", 2'd3, 32'h3, 1'b1);
        reset = 1'b1;
        checkOutput("mid_rst_cap",  2'd3, 32'h0, 1'b0);
        checkOutput("mid_rst_mask", 2'd2, 32'h0, 1'b0);
        checkOutput("mid_rst_edge", 2'd1, 32'h0, 1'b0);
        checkOutput("mid_rst_data", 2'd0, 32'h0, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(2 + DB);
        checkOutput("post_rst_cap_early", 2'd3, 32'h0, 1'b0);
        checkOutput("post_rst_data", 2'd0, 32'hF, 1'b0);
        tick(1);
        checkOutput("post_rst_cap", 2'd3, 32'hF, 1'b0);

`ifdef WAVE_SEL_PIO_IN_DEBOUNCE_EN
        // Short glitch on bit 1 is filtered; a long pulse is accepted.
        applyStimulus(4'h0);
        tick(3 + DB);
        bus_write(2'd3, 32'hF);
        applyStimulus(4'h2);
        tick(10);
        applyStimulus(4'h0);
        tick(30);
        checkOutput("glitch_data", 2'd0, 32'h0, 1'b0);
        checkOutput("glitch_cap",  2'd3, 32'h0, 1'b0);
        applyStimulus(4'h2);
        tick(1 + DB);
        checkOutput("db_data_early", 2'd0, 32'h0, 1'b0);
        tick(1);
        checkOutput("db_data", 2'd0, 32'h2, 1'b0);
        tick(1);
        checkOutput("db_cap", 2'd3, 32'h2, 1'b0);
`endif

        tick(2);
        if (exp_data_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries expected 0", exp_data_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
